// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer for a byte-addressed instruction
// memory (big-endian 4-byte words, read on the falling clock edge). It hands
// fetched words to decode over a valid/ready handshake and holds the PC while
// decode stalls. It also handles redirects and halts when it fetches HALT_WORD.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirect targets.
// A misaligned target then sets the sticky misalign_err and enters HALT.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   ReadAddress     byte address to instruction memory (the PC register)
//   Instruction     word returned by memory for ReadAddress
//   redirect_valid  load redirect_addr (word aligned) into the PC
//   redirect_addr   redirect target byte address
//   out_valid       out_instr/out_pc hold a fetched word
//   out_ready       decode accepts the word this cycle
//   out_instr       fetched instruction
//   out_pc          address out_instr was fetched from
//   halted          high while in HALT
//   fetch_count     completed handshakes, saturating
//   misalign_err    sticky misaligned-redirect flag (0 without MISALIGN_TRAP_EN)
module fetch_sequencer #(
   parameter int unsigned       ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] ReadAddress,
   input  logic [31:0]       Instruction,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count,
   output logic              misalign_err
);

   typedef enum logic [1:0] {S_FETCH, S_STALL, S_HALT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              valid_nxt;
   logic [31:0]       instr_nxt;
   logic [ADDR_W-1:0] opc_nxt;
   logic [CNT_W-1:0]  count_nxt;
   logic              err_nxt;
   logic              accept;
   logic              xfer;

   assign ReadAddress = pc;
   assign accept      = !out_valid || out_ready;
   assign xfer        = out_valid && out_ready;

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      valid_nxt = out_valid;
      instr_nxt = out_instr;
      opc_nxt   = out_pc;
      count_nxt = fetch_count;
      err_nxt   = misalign_err;

      if (xfer && (fetch_count != {CNT_W{1'b1}}))
         count_nxt = fetch_count + CNT_W'(1);

      if (redirect_valid) begin
         // The word in flight from the old PC is dropped; only a word accepted this edge survives.
         pc_nxt    = redirect_addr & ~ADDR_W'(3);
         valid_nxt = 1'b0;
         state_nxt = S_FETCH;
`ifdef MISALIGN_TRAP_EN
         if (redirect_addr[1:0] != 2'b00) begin
            err_nxt   = 1'b1;
            state_nxt = S_HALT;
         end
`endif
      end else begin
         case (state)
            S_FETCH, S_STALL: begin
               if (accept) begin
                  instr_nxt = Instruction;
                  opc_nxt   = pc;
                  valid_nxt = 1'b1;
                  if (Instruction == HALT_WORD) begin
                     state_nxt = S_HALT;
                  end else begin
                     pc_nxt    = pc + ADDR_W'(4);
                     state_nxt = S_FETCH;
                  end
               end else begin
                  state_nxt = S_STALL;
               end
            end
            S_HALT: begin
               if (out_ready)
                  valid_nxt = 1'b0;
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_FETCH;
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_instr   <= '0;
         out_pc      <= '0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         out_valid   <= valid_nxt;
         out_instr   <= instr_nxt;
         out_pc      <= opc_nxt;
         halted      <= (state_nxt == S_HALT);
         fetch_count <= count_nxt;
      end
   end

`ifdef MISALIGN_TRAP_EN
   // Sticky misaligned-redirect flag
   always_ff @(posedge clk) begin
      if (reset)
         misalign_err <= 1'b0;
      else
         misalign_err <= err_nxt;
   end
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. Directed scenarios use constant expectations.
// A randomized run is checked against a cycle-level reference model.
module tb_fetch_sequencer;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned CNT_W  = 16;
   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] ReadAddress;
   logic [31:0]       Instruction = '0;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_addr = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              halted;
   logic [CNT_W-1:0]  fetch_count;
   logic              misalign_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];

   // Reference model state
   logic [ADDR_W-1:0] m_pc;
   logic              m_valid;
   logic [31:0]       m_instr;
   logic [ADDR_W-1:0] m_opc;
   logic              m_halted;
   logic [CNT_W-1:0]  m_count;
   logic              m_err;

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .ReadAddress(ReadAddress), .Instruction(Instruction),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .halted(halted), .fetch_count(fetch_count),
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   // Instruction memory reads on the falling edge
   always @(negedge clk) Instruction = mem[ReadAddress[9:2]];

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   task automatic fill_mem(input bit with_halts);
      for (int i = 0; i < 256; i++)
         mem[i] = (with_halts && $urandom_range(15) == 0) ? HALT : rand_word();
   endtask

   // One clock: update the model from the spec rules, then advance to just past the edge
   task automatic step();
      logic xfer;
      @(negedge clk); #1;
      xfer = m_valid && out_ready;
      if (reset) begin
         m_pc = '0; m_valid = 0; m_instr = '0; m_opc = '0;
         m_halted = 0; m_count = '0; m_err = 0;
      end else begin
         if (xfer && m_count != 16'hFFFF) m_count = m_count + 16'd1;
         if (redirect_valid) begin
            m_pc = {redirect_addr[9:2], 2'b00};
            m_valid = 0;
            m_halted = 0;
            if (TRAP && redirect_addr[1:0] != 2'b00) begin
               m_err = 1;
               m_halted = 1;
            end
         end else if (m_halted) begin
            if (out_ready) m_valid = 0;
         end else if (!m_valid || out_ready) begin
            m_instr = Instruction;
            m_opc = m_pc;
            m_valid = 1;
            if (Instruction == HALT) m_halted = 1;
            else m_pc = m_pc + 10'd4;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1; redirect_valid = 0; out_ready = 0;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; out_ready = 1;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (ReadAddress !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", ReadAddress); end
      checks++; if (fetch_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
      checks++; if ({halted, misalign_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {halted, misalign_err}); end
      checks++; if ({out_instr, out_pc} !== 42'h0) begin errors++; $display("FAIL reset_out: got %h/%h want 0/0", out_instr, out_pc); end
   endtask

   task automatic test_basic();
      mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003; mem[2] = 32'h0109_5020;
      do_reset();
      out_ready = 1;
      step();
      checks++; if ({out_valid, out_pc, out_instr} !== {1'b1, 10'h000, 32'h2008_0005}) begin errors++; $display("FAIL basic_w0: got %b %h %h want 1 000 20080005", out_valid, out_pc, out_instr); end
      step();
      checks++; if ({out_pc, out_instr} !== {10'h004, 32'h2009_0003}) begin errors++; $display("FAIL basic_w1: got %h %h want 004 20090003", out_pc, out_instr); end
      step();
      checks++; if ({out_pc, out_instr} !== {10'h008, 32'h0109_5020}) begin errors++; $display("FAIL basic_w2: got %h %h want 008 01095020", out_pc, out_instr); end
      step();
      checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", fetch_count); end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1;
      step(); step();
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({out_valid, out_pc, out_instr, ReadAddress} !== {1'b1, 10'h004, mem[1], 10'h008}) begin
            errors++; $display("FAIL stall_hold%0d: got %b %h %h ra=%h want 1 004 %h ra=008", i, out_valid, out_pc, out_instr, ReadAddress, mem[1]);
         end
      end
      out_ready = 1;
      step();
      checks++; if ({out_pc, out_instr} !== {10'h008, mem[2]}) begin errors++; $display("FAIL stall_resume: got %h %h want 008 %h", out_pc, out_instr, mem[2]); end
      step();
      checks++; if (out_pc !== 10'h00C) begin errors++; $display("FAIL stall_next: got %h want 00c", out_pc); end
   endtask

   task automatic test_redirect_wrap();
      do_reset();
      out_ready = 1;
      step();
      out_ready = 0; redirect_valid = 1; redirect_addr = 10'h3FC;
      step();
      redirect_valid = 0;
      checks++; if ({out_valid, ReadAddress, fetch_count} !== {1'b0, 10'h3FC, 16'd0}) begin errors++; $display("FAIL redir_drop: got %b ra=%h cnt=%0d want 0 ra=3fc cnt=0", out_valid, ReadAddress, fetch_count); end
      out_ready = 1;
      step();
      checks++; if ({out_valid, out_pc, out_instr, ReadAddress} !== {1'b1, 10'h3FC, mem[255], 10'h000}) begin errors++; $display("FAIL redir_first: got %b %h %h ra=%h want 1 3fc %h ra=000", out_valid, out_pc, out_instr, ReadAddress, mem[255]); end
      step();
      checks++; if ({out_pc, out_instr} !== {10'h000, mem[0]}) begin errors++; $display("FAIL redir_wrap: got %h %h want 000 %h", out_pc, out_instr, mem[0]); end
   endtask

   task automatic test_halt();
      logic [31:0] saved;
      saved = mem[3];
      mem[3] = HALT;
      do_reset();
      out_ready = 1;
      step(); step(); step(); step();
      checks++; if ({out_valid, out_pc, out_instr, halted, ReadAddress} !== {1'b1, 10'h00C, HALT, 1'b1, 10'h00C}) begin
         errors++; $display("FAIL halt_deliver: got %b %h %h h=%b ra=%h want 1 00c ffffffff h=1 ra=00c", out_valid, out_pc, out_instr, halted, ReadAddress);
      end
      step();
      checks++; if ({out_valid, halted} !== 2'b01) begin errors++; $display("FAIL halt_drain: got v=%b h=%b want v=0 h=1", out_valid, halted); end
      step();
      checks++; if ({out_valid, ReadAddress, fetch_count} !== {1'b0, 10'h00C, 16'd4}) begin errors++; $display("FAIL halt_idle: got v=%b ra=%h cnt=%0d want v=0 ra=00c cnt=4", out_valid, ReadAddress, fetch_count); end
      redirect_valid = 1; redirect_addr = 10'h000;
      step();
      redirect_valid = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_exit: got %b want 0", halted); end
      step();
      checks++; if ({out_valid, out_pc} !== {1'b1, 10'h000}) begin errors++; $display("FAIL halt_refetch: got %b %h want 1 000", out_valid, out_pc); end
      mem[3] = saved;
   endtask

   task automatic test_misalign();
      do_reset();
      out_ready = 1;
      step();
      redirect_valid = 1; redirect_addr = 10'h00A;
      step();
      redirect_valid = 0;
      checks++; if ({out_valid, ReadAddress, halted, misalign_err} !== {1'b0, 10'h008, TRAP, TRAP}) begin
         errors++; $display("FAIL misalign_redir: got v=%b ra=%h h=%b e=%b want v=0 ra=008 h=%b e=%b", out_valid, ReadAddress, halted, misalign_err, TRAP, TRAP);
      end
      step();
      if (TRAP) begin
         checks++; if ({out_valid, ReadAddress, halted} !== {1'b0, 10'h008, 1'b1}) begin errors++; $display("FAIL misalign_nofetch: got v=%b ra=%h h=%b want v=0 ra=008 h=1", out_valid, ReadAddress, halted); end
         redirect_valid = 1; redirect_addr = 10'h000;
         step();
         redirect_valid = 0;
         checks++; if ({halted, misalign_err} !== 2'b01) begin errors++; $display("FAIL misalign_sticky: got h=%b e=%b want h=0 e=1", halted, misalign_err); end
      end else begin
         checks++; if ({out_valid, out_pc, out_instr, misalign_err} !== {1'b1, 10'h008, mem[2], 1'b0}) begin
            errors++; $display("FAIL misalign_fetch: got %b %h %h e=%b want 1 008 %h e=0", out_valid, out_pc, out_instr, misalign_err, mem[2]);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      out_ready = 1;
      for (int i = 0; i < 6; i++) step();
      out_ready = 0;
      step();
      checks++; if ({out_valid, fetch_count} !== {1'b1, 16'd5}) begin errors++; $display("FAIL rst_stall_pre: got v=%b cnt=%0d want v=1 cnt=5", out_valid, fetch_count); end
      reset = 1; out_ready = 1;
      step();
      reset = 0;
      checks++; if ({out_valid, fetch_count, ReadAddress} !== {1'b0, 16'd0, 10'h000}) begin errors++; $display("FAIL rst_stall: got v=%b cnt=%0d ra=%h want v=0 cnt=0 ra=000", out_valid, fetch_count, ReadAddress); end
   endtask

   task automatic test_saturate();
      do_reset();
      out_ready = 1;
      for (int i = 0; i < 65537; i++) step();
      checks++; if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", fetch_count); end
      step();
      checks++; if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", fetch_count); end
   endtask

   task automatic test_random();
      fill_mem(1'b1);
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         reset          = ($urandom_range(199) == 0);
         out_ready      = ($urandom_range(9) < 7);
         redirect_valid = ($urandom_range(19) == 0);
         redirect_addr  = ADDR_W'($urandom);
         step();
         checks++;
         if ({ReadAddress, out_valid, out_instr, out_pc, halted, fetch_count, misalign_err} !==
             {m_pc, m_valid, m_instr, m_opc, m_halted, m_count, m_err}) begin
            errors++;
            $display("FAIL random_cyc%0d: got ra=%h v=%b i=%h pc=%h h=%b c=%0d e=%b want ra=%h v=%b i=%h pc=%h h=%b c=%0d e=%b",
                     i, ReadAddress, out_valid, out_instr, out_pc, halted, fetch_count, misalign_err,
                     m_pc, m_valid, m_instr, m_opc, m_halted, m_count, m_err);
         end
      end
      reset = 0; redirect_valid = 0;
   endtask

   initial begin
      fill_mem(1'b0);
      test_reset();
      test_basic();
      test_stall();
      test_redirect_wrap();
      test_halt();
      test_misalign();
      test_reset_mid_stall();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
